// File: rtl/axi_eth_pkg.sv
// axi_eth_pkg: shared definitions for the MAC-side transmit path.
//   - arbiter state encoding and the 4-bit state codes driven onto debug buses
//   - beat width constants for the 64-bit txd stream (data, keep, packed beat)
package axi_eth_pkg;

  localparam int AXI_ETH_DATA_W = 64;
  localparam int AXI_ETH_KEEP_W = 8;
  // Packed beat layout: {tlast, tkeep, tdata}
  localparam int AXI_ETH_BEAT_W = AXI_ETH_DATA_W + AXI_ETH_KEEP_W + 1;

  localparam logic [3:0] ARB_IDLE   = 4'd0;
  localparam logic [3:0] ARB_GRANT0 = 4'd1;
  localparam logic [3:0] ARB_GRANT1 = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/axi_eth_axis_reg.sv
// axi_eth_axis_reg: single-entry output register slice.
//   clk      sole clock
//   resetn   synchronous active-low reset (clears valid and payload)
//   load     capture din this cycle (caller guarantees the slot is free or draining)
//   drain    downstream ready; empties the slot when nothing is loaded
//   din      packed beat {tlast, tkeep, tdata}
//   vld      registered valid
//   dout     registered beat
// Load and drain in the same cycle replace the beat, giving one beat per cycle.
module axi_eth_axis_reg
  import axi_eth_pkg::*;
#(
  parameter int DATA_W = AXI_ETH_BEAT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] din,
  output logic              vld,
  output logic [DATA_W-1:0] dout
);

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;

  // Stage p0: output register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (load) begin
      vld_p0  <= 1'b1;
      data_p0 <= din;
    end else if (drain) begin
      vld_p0  <= 1'b0;
    end
  end

  assign vld  = vld_p0;
  assign dout = data_p0;

endmodule

// File: rtl/axi_eth_tx_arb.sv
// axi_eth_tx_arb: frame-granular two-source arbiter for the txd stream feeding
// axi_eth_ofm. A grant lasts from the first beat of a frame through its tlast
// beat, so frames never interleave. Arbitration costs one idle cycle per frame.
//   mm2s_clk / mm2s_resetn   clock, synchronous active-low reset
//   s0_* / s1_*              AXI-Stream sources (tdata, tkeep, tlast, tvalid, tready)
//   txd_*                    registered arbitrated stream to axi_eth_ofm
//   arb_grant                one-hot current grant, 0 while idle
//   arb_fsm_dbg              state code (ARB_IDLE/ARB_GRANT0/ARB_GRANT1)
//   s0_frame_cnt/s1_frame_cnt completed frames per source, wrapping
// Build option AXI_ETH_TX_ARB_PRI_EN: source 0 has strict priority in IDLE;
// otherwise sources alternate on ties (round-robin via last_grant).
module axi_eth_tx_arb
  import axi_eth_pkg::*;
#(
  parameter string C_FAMILY    = "",
  parameter int    C_CNT_WIDTH = 16
) (
  input  logic                      mm2s_clk,
  input  logic                      mm2s_resetn,
  input  logic [AXI_ETH_DATA_W-1:0] s0_tdata,
  input  logic [AXI_ETH_KEEP_W-1:0] s0_tkeep,
  input  logic                      s0_tlast,
  input  logic                      s0_tvalid,
  output logic                      s0_tready,
  input  logic [AXI_ETH_DATA_W-1:0] s1_tdata,
  input  logic [AXI_ETH_KEEP_W-1:0] s1_tkeep,
  input  logic                      s1_tlast,
  input  logic                      s1_tvalid,
  output logic                      s1_tready,
  output logic [AXI_ETH_DATA_W-1:0] txd_tdata,
  output logic [AXI_ETH_KEEP_W-1:0] txd_tkeep,
  output logic                      txd_tlast,
  output logic                      txd_tvalid,
  input  logic                      txd_tready,
  output logic [1:0]                arb_grant,
  output logic [3:0]                arb_fsm_dbg,
  output logic [C_CNT_WIDTH-1:0]    s0_frame_cnt,
  output logic [C_CNT_WIDTH-1:0]    s1_frame_cnt
);

  // The family string only names a scope for debug; the logic is generic.
  if (C_FAMILY == "") begin : g_generic
  end else begin : g_family
  end

  arb_state_t                state;
  logic                      last_grant;
  logic                      slot_free;
  logic                      acc0;
  logic                      acc1;
  logic                      load;
  logic                      pick0;
  logic [AXI_ETH_BEAT_W-1:0] beat_in;
  logic [AXI_ETH_BEAT_W-1:0] beat_out;

  // Ready follows the output slot combinationally so a draining slot can be
  // refilled in the same cycle.
  assign slot_free = !txd_tvalid || txd_tready;
  assign s0_tready = (state == ST_GRANT0) && slot_free;
  assign s1_tready = (state == ST_GRANT1) && slot_free;
  assign acc0      = s0_tvalid && s0_tready;
  assign acc1      = s1_tvalid && s1_tready;
  assign load      = acc0 || acc1;
  assign beat_in   = (state == ST_GRANT1) ? {s1_tlast, s1_tkeep, s1_tdata}
                                          : {s0_tlast, s0_tkeep, s0_tdata};

`ifdef AXI_ETH_TX_ARB_PRI_EN
  assign pick0 = s0_tvalid;
`else
  // On a tie, source 0 wins only if source 1 had the previous grant.
  assign pick0 = s0_tvalid && (!s1_tvalid || last_grant);
`endif

  always_ff @(posedge mm2s_clk) begin
    if (!mm2s_resetn) begin
      state        <= ST_IDLE;
      last_grant   <= 1'b1;
      arb_grant    <= 2'b00;
      arb_fsm_dbg  <= ARB_IDLE;
      s0_frame_cnt <= '0;
      s1_frame_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick0) begin
            state       <= ST_GRANT0;
            arb_grant   <= 2'b01;
            arb_fsm_dbg <= ARB_GRANT0;
          end else if (s1_tvalid) begin
            state       <= ST_GRANT1;
            arb_grant   <= 2'b10;
            arb_fsm_dbg <= ARB_GRANT1;
          end
        end
        ST_GRANT0: begin
          if (acc0 && s0_tlast) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b0;
            arb_grant    <= 2'b00;
            arb_fsm_dbg  <= ARB_IDLE;
            s0_frame_cnt <= s0_frame_cnt + 1'b1;
          end
        end
        ST_GRANT1: begin
          if (acc1 && s1_tlast) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            arb_grant    <= 2'b00;
            arb_fsm_dbg  <= ARB_IDLE;
            s1_frame_cnt <= s1_frame_cnt + 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          arb_grant   <= 2'b00;
          arb_fsm_dbg <= ARB_IDLE;
        end
      endcase
    end
  end

  axi_eth_axis_reg #(
    .DATA_W (AXI_ETH_BEAT_W)
  ) u_out_reg (
    .clk    (mm2s_clk),
    .resetn (mm2s_resetn),
    .load   (load),
    .drain  (txd_tready),
    .din    (beat_in),
    .vld    (txd_tvalid),
    .dout   (beat_out)
  );

  assign {txd_tlast, txd_tkeep, txd_tdata} = beat_out;

endmodule

// File: tb/tb_axi_eth_tx_arb.sv
module tb_axi_eth_tx_arb;

  localparam int CW = 2;

  logic          mm2s_clk = 1'b0;
  logic          mm2s_resetn = 1'b0;
  logic [63:0]   s0_tdata = '0, s1_tdata = '0;
  logic [7:0]    s0_tkeep = '0, s1_tkeep = '0;
  logic          s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic          s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic          s0_tready, s1_tready;
  logic [63:0]   txd_tdata;
  logic [7:0]    txd_tkeep;
  logic          txd_tlast, txd_tvalid;
  logic          txd_tready = 1'b1;
  logic [1:0]    arb_grant;
  logic [3:0]    arb_fsm_dbg;
  logic [CW-1:0] s0_frame_cnt, s1_frame_cnt;

  axi_eth_tx_arb #(.C_FAMILY(""), .C_CNT_WIDTH(CW)) dut (
    .mm2s_clk(mm2s_clk), .mm2s_resetn(mm2s_resetn),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .txd_tdata(txd_tdata), .txd_tkeep(txd_tkeep), .txd_tlast(txd_tlast),
    .txd_tvalid(txd_tvalid), .txd_tready(txd_tready),
    .arb_grant(arb_grant), .arb_fsm_dbg(arb_fsm_dbg),
    .s0_frame_cnt(s0_frame_cnt), .s1_frame_cnt(s1_frame_cnt)
  );

  always #5 mm2s_clk = ~mm2s_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (got running, want finished)");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endfunction

  // ---------------- source engine / monitor ----------------
  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t       q0[$], q1[$], exp_q[$];
  logic [1:0]  gq[$];
  bit          a0, a1, stall0, stall1, tr_toggle, mon_on, chk_gap;
  bit          hold_prev, seen_last, want_gap;
  logic [63:0] hd;
  logic [7:0]  hk;
  logic        hl;
  logic [1:0]  prev_g;
  int          gap;

  function automatic beat_t mk(int src, int fid, int b, bit last);
    beat_t r;
    r.d = {8'(8'hC0 + src), 8'(fid), 8'(b), 40'h12_3456_789A};
    r.k = 8'(fid * 16 + b + 1);
    r.l = last;
    return r;
  endfunction

  task automatic load_frame(int src, int fid, int n);
    for (int b = 0; b < n; b++) begin
      if (src == 0) q0.push_back(mk(0, fid, b, b == n - 1));
      else          q1.push_back(mk(1, fid, b, b == n - 1));
    end
  endtask

  task automatic expect_frame(int src, int fid, int n);
    for (int b = 0; b < n; b++) exp_q.push_back(mk(src, fid, b, b == n - 1));
  endtask

  task automatic drive_src();
    s0_tvalid = (q0.size() > 0) && !stall0;
    s1_tvalid = (q1.size() > 0) && !stall1;
    if (q0.size() > 0) begin s0_tdata = q0[0].d; s0_tkeep = q0[0].k; s0_tlast = q0[0].l; end
    else begin s0_tdata = '0; s0_tkeep = '0; s0_tlast = 1'b0; end
    if (q1.size() > 0) begin s1_tdata = q1[0].d; s1_tkeep = q1[0].k; s1_tlast = q1[0].l; end
    else begin s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0; end
  endtask

  task automatic monitor();
    beat_t e;
    if (!mon_on) return;
    if (hold_prev) begin
      chk("hold_vld",  txd_tvalid, 1'b1);
      chk("hold_data", txd_tdata, hd);
      chk("hold_keep", txd_tkeep, hk);
      chk("hold_last", txd_tlast, hl);
    end
    if (!txd_tvalid) gap++;
    if (txd_tvalid && txd_tready) begin
      chk("beat_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_data", txd_tdata, e.d);
        chk("beat_keep", txd_tkeep, e.k);
        chk("beat_last", txd_tlast, e.l);
      end
      if (want_gap && chk_gap) chk("frame_gap", gap, 1);
      want_gap = 1'b0;
      if (txd_tlast) begin gap = 0; want_gap = 1'b1; seen_last = 1'b1; end
    end
    hold_prev = txd_tvalid && !txd_tready;
    hd = txd_tdata; hk = txd_tkeep; hl = txd_tlast;
    if (arb_grant != prev_g) begin gq.push_back(arb_grant); prev_g = arb_grant; end
  endtask

  task automatic step();
    @(posedge mm2s_clk); #1;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    a0 = 1'b0; a1 = 1'b0;
    txd_tready = tr_toggle ? ~txd_tready : 1'b1;
    drive_src();
    @(negedge mm2s_clk);
    a0 = s0_tvalid && s0_tready;
    a1 = s1_tvalid && s1_tready;
    monitor();
  endtask

  task automatic run_until_idle(string name, int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      step();
      done = (q0.size() == 0) && (q1.size() == 0) && (exp_q.size() == 0) && !txd_tvalid;
    end
    chk(name, done, 1'b1);
  endtask

  task automatic clear_mon();
    exp_q.delete(); gq.delete();
    hold_prev = 1'b0; seen_last = 1'b0; want_gap = 1'b0; gap = 0; prev_g = 2'b00;
    a0 = 1'b0; a1 = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_s0_tready", s0_tready, 1'b0);
    chk("rst_s1_tready", s1_tready, 1'b0);
    chk("rst_txd_tvalid", txd_tvalid, 1'b0);
    chk("rst_txd_tlast", txd_tlast, 1'b0);
    chk("rst_txd_tdata", txd_tdata, 64'h0);
    chk("rst_txd_tkeep", txd_tkeep, 8'h0);
    chk("rst_arb_grant", arb_grant, 2'b00);
    chk("rst_fsm_dbg", arb_fsm_dbg, 4'h0);
    chk("rst_s0_cnt", s0_frame_cnt, 0);
    chk("rst_s1_cnt", s1_frame_cnt, 0);
  endtask

  // Queues already loaded are presented during reset ("pending from reset").
  task automatic do_reset();
    mm2s_resetn = 1'b0;
    stall0 = 1'b0; stall1 = 1'b0; tr_toggle = 1'b0; txd_tready = 1'b1;
    clear_mon();
    drive_src();
    repeat (3) @(posedge mm2s_clk);
    #1 mm2s_resetn = 1'b1;
    @(negedge mm2s_clk);
    chk_reset_vals();
  endtask

  // ---------------- table-driven single-source frame ----------------
  typedef struct {
    logic          s0v, s0l;
    logic [63:0]   s0d;
    logic [7:0]    s0k;
    logic          trdy;
    logic          e_s0r, e_tv, e_tl;
    logic [63:0]   e_td;
    logic [7:0]    e_tk;
    logic [1:0]    e_g;
    logic [3:0]    e_dbg;
    logic [CW-1:0] e_c0;
  } vec_t;

  function automatic vec_t mkv(logic s0v, logic s0l, int di, logic trdy,
                               logic e_s0r, logic e_tv, logic e_tl, int ei,
                               logic [1:0] e_g, logic [3:0] e_dbg, int e_c0);
    vec_t v;
    v.s0v = s0v; v.s0l = s0l; v.trdy = trdy;
    v.s0d = 64'hA5A5_0000_0000_0010 + 64'(di);
    v.s0k = 8'(8'h30 + di);
    v.e_s0r = e_s0r; v.e_tv = e_tv; v.e_tl = e_tl;
    v.e_td = 64'hA5A5_0000_0000_0010 + 64'(ei);
    v.e_tk = 8'(8'h30 + ei);
    v.e_g = e_g; v.e_dbg = e_dbg; v.e_c0 = CW'(e_c0);
    return v;
  endfunction

  vec_t tbl[8];

  initial begin
    mon_on = 1'b0; chk_gap = 1'b0; tr_toggle = 1'b0; stall0 = 1'b0; stall1 = 1'b0;
    clear_mon();

    //                s0v l  di trdy s0r tv tl ei grant  dbg c0
    tbl[0] = mkv(1, 0, 0, 1,   0,  0, 0, 0, 2'b00, 0, 0);
    tbl[1] = mkv(1, 0, 0, 1,   1,  0, 0, 0, 2'b01, 1, 0);
    tbl[2] = mkv(1, 0, 1, 1,   1,  1, 0, 0, 2'b01, 1, 0);
    tbl[3] = mkv(1, 0, 2, 0,   0,  1, 0, 1, 2'b01, 1, 0);
    tbl[4] = mkv(1, 0, 2, 1,   1,  1, 0, 1, 2'b01, 1, 0);
    tbl[5] = mkv(1, 1, 3, 1,   1,  1, 0, 2, 2'b01, 1, 0);
    tbl[6] = mkv(0, 0, 0, 1,   0,  1, 1, 3, 2'b00, 0, 1);
    tbl[7] = mkv(0, 0, 0, 1,   0,  0, 0, 0, 2'b00, 0, 1);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge mm2s_clk); #1;
      s0_tvalid = tbl[i].s0v; s0_tlast = tbl[i].s0l;
      s0_tdata = tbl[i].s0d; s0_tkeep = tbl[i].s0k;
      s1_tvalid = 1'b0; txd_tready = tbl[i].trdy;
      @(negedge mm2s_clk);
      chk($sformatf("v%0d_s0_tready", i), s0_tready, tbl[i].e_s0r);
      chk($sformatf("v%0d_s1_tready", i), s1_tready, 1'b0);
      chk($sformatf("v%0d_txd_tvalid", i), txd_tvalid, tbl[i].e_tv);
      if (tbl[i].e_tv) begin
        chk($sformatf("v%0d_txd_tdata", i), txd_tdata, tbl[i].e_td);
        chk($sformatf("v%0d_txd_tkeep", i), txd_tkeep, tbl[i].e_tk);
        chk($sformatf("v%0d_txd_tlast", i), txd_tlast, tbl[i].e_tl);
      end
      chk($sformatf("v%0d_arb_grant", i), arb_grant, tbl[i].e_g);
      chk($sformatf("v%0d_fsm_dbg", i), arb_fsm_dbg, tbl[i].e_dbg);
      chk($sformatf("v%0d_s0_cnt", i), s0_frame_cnt, tbl[i].e_c0);
      chk($sformatf("v%0d_s1_cnt", i), s1_frame_cnt, 0);
    end

    // ---- tie from reset: two 3-beat frames on each source ----
    load_frame(0, 1, 3); load_frame(0, 2, 3);
    load_frame(1, 1, 3); load_frame(1, 2, 3);
    do_reset();
`ifdef AXI_ETH_TX_ARB_PRI_EN
    expect_frame(0, 1, 3); expect_frame(0, 2, 3); expect_frame(1, 1, 3); expect_frame(1, 2, 3);
`else
    expect_frame(0, 1, 3); expect_frame(1, 1, 3); expect_frame(0, 2, 3); expect_frame(1, 2, 3);
`endif
    mon_on = 1'b1; chk_gap = 1'b1;
    run_until_idle("tie_timeout", 60);
    chk("tie_grant_count", gq.size(), 8);
    if (gq.size() == 8) begin
`ifdef AXI_ETH_TX_ARB_PRI_EN
      chk("tie_g2", gq[2], 2'b01); chk("tie_g4", gq[4], 2'b10);
`else
      chk("tie_g2", gq[2], 2'b10); chk("tie_g4", gq[4], 2'b01);
`endif
      chk("tie_g0", gq[0], 2'b01); chk("tie_g1", gq[1], 2'b00);
      chk("tie_g3", gq[3], 2'b00); chk("tie_g6", gq[6], 2'b10);
    end
    chk("tie_s0_cnt", s0_frame_cnt, 2);
    chk("tie_s1_cnt", s1_frame_cnt, 2);

    // ---- backpressure: txd_tready toggles during a 6-beat s1 frame ----
    load_frame(1, 3, 6);
    do_reset();
    expect_frame(1, 3, 6);
    chk_gap = 1'b0; tr_toggle = 1'b1;
    run_until_idle("bp_timeout", 60);
    tr_toggle = 1'b0;
    chk("bp_s1_cnt", s1_frame_cnt, 1);
    chk("bp_s0_cnt", s0_frame_cnt, 0);

    // ---- source stall: s0 drops valid for 5 cycles mid-frame ----
    load_frame(0, 4, 4);
    do_reset();
    expect_frame(0, 4, 4); expect_frame(1, 5, 2);
    chk_gap = 1'b1;
    begin
      bit reached = 1'b0;
      for (int i = 0; i < 20 && !reached; i++) begin
        step();
        reached = (q0.size() <= 2);
      end
      chk("stall_reach", reached, 1'b1);
    end
    load_frame(1, 5, 2);
    stall0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall%0d_s1_tready", i), s1_tready, 1'b0);
      chk($sformatf("stall%0d_grant", i), arb_grant, 2'b01);
    end
    stall0 = 1'b0;
    run_until_idle("stall_timeout", 40);
    chk("stall_s0_cnt", s0_frame_cnt, 1);
    chk("stall_s1_cnt", s1_frame_cnt, 1);

    // ---- reset mid-frame on beat 2 of 5 ----
    load_frame(0, 7, 5);
    do_reset();
    mon_on = 1'b0;
    begin
      bit reached = 1'b0;
      for (int i = 0; i < 20 && !reached; i++) begin
        step();
        reached = (q0.size() <= 3);
      end
      chk("mrst_reach", reached, 1'b1);
    end
    mm2s_resetn = 1'b0;
    @(posedge mm2s_clk); #1;
    mm2s_resetn = 1'b1;
    q0.delete(); q1.delete();
    clear_mon();
    load_frame(0, 8, 2); load_frame(1, 9, 2);
    drive_src();
    @(negedge mm2s_clk);
    chk_reset_vals();
    expect_frame(0, 8, 2); expect_frame(1, 9, 2);
    mon_on = 1'b1;
    run_until_idle("mrst_timeout", 40);
    chk("mrst_first_grant", (gq.size() > 0) ? gq[0] : 2'b11, 2'b01);
    chk("mrst_s0_cnt", s0_frame_cnt, 1);
    chk("mrst_s1_cnt", s1_frame_cnt, 1);

    // ---- counter wrap: 5 frames on s0 with a 2-bit counter ----
    for (int f = 0; f < 5; f++) load_frame(0, 16 + f, 2);
    do_reset();
    for (int f = 0; f < 5; f++) expect_frame(0, 16 + f, 2);
    run_until_idle("wrap_timeout", 60);
    chk("wrap_s0_cnt", s0_frame_cnt, 1);
    chk("wrap_s1_cnt", s1_frame_cnt, 0);

    // ---- continuous s0 frames with s1 waiting ----
    for (int f = 0; f < 3; f++) load_frame(0, 24 + f, 2);
    load_frame(1, 30, 2);
    do_reset();
`ifdef AXI_ETH_TX_ARB_PRI_EN
    expect_frame(0, 24, 2); expect_frame(0, 25, 2); expect_frame(0, 26, 2); expect_frame(1, 30, 2);
`else
    expect_frame(0, 24, 2); expect_frame(1, 30, 2); expect_frame(0, 25, 2); expect_frame(0, 26, 2);
`endif
    run_until_idle("pri_timeout", 60);
`ifdef AXI_ETH_TX_ARB_PRI_EN
    chk("pri_g2", (gq.size() > 2) ? gq[2] : 2'b11, 2'b01);
`else
    chk("pri_g2", (gq.size() > 2) ? gq[2] : 2'b11, 2'b10);
`endif
    chk("pri_s1_cnt", s1_frame_cnt, 1);
    chk("pri_s0_cnt", s0_frame_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
